// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_sb
// Purpose  : Parametrised register file with one write port, two registered
//            read ports (write-through bypass), an optional hard-wired zero
//            register and a per-register pending scoreboard.
// Ports    : clk                 - rising-edge clock
//            reset               - asynchronous active-low clear
//            wr_en/addr/data     - write port (also clears pending)
//            lock_en/lock_addr   - marks a register pending
//            rd_addr1/2          - read addresses, sampled every edge
//            rd_data1/2          - registered read data
//            rd_busy1/2          - registered pending status of read targets
//            all_idle            - registered, 1 when nothing is pending
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  output logic              all_idle
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             pend_q, pend_d;
  logic [DATA_W-1:0]            rd_data1_q, rd_data1_d;
  logic [DATA_W-1:0]            rd_data2_q, rd_data2_d;
  logic                         rd_busy1_q, rd_busy1_d;
  logic                         rd_busy2_q, rd_busy2_d;
  logic                         all_idle_q, all_idle_d;
  logic                         w_wr_ok;
  logic                         w_lock_ok;

  always_comb begin
    // With a hard-wired zero register, address 0 never accepts writes or
    // locks, so mem_q[0] and pend_q[0] stay at their reset value of 0.
    w_wr_ok   = wr_en;
    w_lock_ok = lock_en;
    if ((ZERO_REG != 0) && (wr_addr == '0)) begin
      w_wr_ok = 1'b0;
    end
    if ((ZERO_REG != 0) && (lock_addr == '0)) begin
      w_lock_ok = 1'b0;
    end

    mem_d  = mem_q;
    pend_d = pend_q;
    if (w_wr_ok) begin
      mem_d[wr_addr]  = wr_data;
      pend_d[wr_addr] = 1'b0;
    end
    // Applied after the write-clear so a same-address lock wins.
    if (w_lock_ok) begin
      pend_d[lock_addr] = 1'b1;
    end

    // Reading the post-write array is the write-through bypass: mem_d only
    // differs from mem_q at the address being written this cycle.
    rd_data1_d = mem_d[rd_addr1];
    rd_data2_d = mem_d[rd_addr2];
    rd_busy1_d = pend_d[rd_addr1];
    rd_busy2_d = pend_d[rd_addr2];
    all_idle_d = ~|pend_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q      <= '0;
      pend_q     <= '0;
      rd_data1_q <= '0;
      rd_data2_q <= '0;
      rd_busy1_q <= 1'b0;
      rd_busy2_q <= 1'b0;
      all_idle_q <= 1'b1;
    end else begin
      mem_q      <= mem_d;
      pend_q     <= pend_d;
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
      rd_busy1_q <= rd_busy1_d;
      rd_busy2_q <= rd_busy2_d;
      all_idle_q <= all_idle_d;
    end
  end

  assign rd_data1 = rd_data1_q;
  assign rd_data2 = rd_data2_q;
  assign rd_busy1 = rd_busy1_q;
  assign rd_busy2 = rd_busy2_q;
  assign all_idle = all_idle_q;

endmodule
`default_nettype wire
